// File: rtl/sv_seq_pkg.sv
// Shared types and helpers for the SelectTest / Validate round sequencer.
package sv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_WAIT,
    SEL_PULSE,
    SEL_WAIT,
    GAP,
    VAL_PULSE,
    VAL_WAIT,
    DONE
  } seq_state_e;

  // Width of the shared delay/timeout counter: wide enough for the largest load value.
  function automatic int cnt_width(input int start_delay, input int gap_cycles,
                                   input int timeout_cycles);
    int m;
    m = start_delay;
    if (gap_cycles > m) m = gap_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_delay_counter.sv
// Loadable down-counter with a zero flag; stops at zero rather than wrapping.
module seq_delay_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/select_validate_sequencer.sv
// Round sequencer: select_test strobe, wait ack, gap, validate strobe, wait ack; aborts on timeout.
//   state      | meaning
//   IDLE       | waiting for start
//   START_WAIT | counting START_DELAY before the first round
//   SEL_PULSE  | select_test strobe
//   SEL_WAIT   | waiting for select_done (timeout guarded)
//   GAP        | counting GAP_CYCLES
//   VAL_PULSE  | validate strobe
//   VAL_WAIT   | waiting for validate_done (timeout guarded)
//   DONE       | finish pulse
module select_validate_sequencer
  import sv_seq_pkg::*;
#(
  parameter int NUM_ROUNDS     = 5,
  parameter int START_DELAY    = 10,
  parameter int GAP_CYCLES     = 5,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CTR_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             select_test,
  input  logic             select_done,
  output logic             validate,
  input  logic             validate_done,
  output logic [CTR_W-1:0] round,
  output logic             busy,
  output logic             finish,
  output logic             timeout_err
);

  localparam int DW = cnt_width(START_DELAY, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [DW-1:0]    START_LD   = DW'(START_DELAY - 1);
  localparam logic [DW-1:0]    GAP_LD     = DW'(GAP_CYCLES - 1);
  localparam logic [DW-1:0]    TO_LD      = DW'(TIMEOUT_CYCLES - 1);
  localparam logic [CTR_W-1:0] LAST_ROUND = CTR_W'(NUM_ROUNDS - 1);

  if ((NUM_ROUNDS < 1) || (longint'(NUM_ROUNDS) >= (longint'(1) << CTR_W))) begin : g_bad_rounds
    $error("NUM_ROUNDS must be >= 1 and fit in CTR_W bits");
  end

  seq_state_e    state;
  logic          cnt_ld;
  logic [DW-1:0] cnt_ld_val;
  logic          cnt_en;
  logic          cnt_zero;

  // One counter serves start delay, gap and both wait timeouts; they never overlap.
  always_comb begin
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    cnt_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_ld     = 1'b1;
          cnt_ld_val = START_LD;
        end
      end
      START_WAIT, GAP, VAL_WAIT: cnt_en = 1'b1;
      SEL_PULSE, VAL_PULSE: begin
        cnt_ld     = 1'b1;
        cnt_ld_val = TO_LD;
      end
      SEL_WAIT: begin
        if (select_done && (GAP_CYCLES > 0)) begin
          cnt_ld     = 1'b1;
          cnt_ld_val = GAP_LD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  seq_delay_counter #(.W(DW)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_ld),
    .load_val (cnt_ld_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      round       <= '0;
      select_test <= 1'b0;
      validate    <= 1'b0;
      busy        <= 1'b0;
      finish      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      select_test <= 1'b0;
      validate    <= 1'b0;
      finish      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= START_WAIT;
            busy        <= 1'b1;
            round       <= '0;
            timeout_err <= 1'b0;
          end
        end
        START_WAIT: begin
          if (cnt_zero) begin
            state       <= SEL_PULSE;
            select_test <= 1'b1;
          end
        end
        SEL_PULSE: state <= SEL_WAIT;
        SEL_WAIT: begin
          // done is checked before expiry so a coincident ack still counts
          if (select_done) begin
            if (GAP_CYCLES == 0) begin
              state    <= VAL_PULSE;
              validate <= 1'b1;
            end else begin
              state <= GAP;
            end
          end else if (cnt_zero) begin
            state       <= DONE;
            finish      <= 1'b1;
            timeout_err <= 1'b1;
          end
        end
        GAP: begin
          if (cnt_zero) begin
            state    <= VAL_PULSE;
            validate <= 1'b1;
          end
        end
        VAL_PULSE: state <= VAL_WAIT;
        VAL_WAIT: begin
          if (validate_done) begin
            if (round == LAST_ROUND) begin
              state  <= DONE;
              finish <= 1'b1;
            end else begin
              state       <= SEL_PULSE;
              select_test <= 1'b1;
              round       <= round + 1'b1;
            end
          end else if (cnt_zero) begin
            state       <= DONE;
            finish      <= 1'b1;
            timeout_err <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_select_validate_sequencer.sv
// Bench for select_validate_sequencer: three parameterisations, randomized ack delays,
// expected strobe/finish/round/timeout timeline computed per run from the sequencing rules.
module tb_select_validate_sequencer;

  localparam int N = 3;
  localparam int P_NR[N]  = '{5, 5, 3};
  localparam int P_SD[N]  = '{10, 10, 2};
  localparam int P_GAP[N] = '{5, 5, 0};
  localparam int P_TO[N]  = '{1024, 16, 16};

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i[N];
  logic       sel_done_i[N];
  logic       val_done_i[N];
  logic       sel_o[N];
  logic       val_o[N];
  logic       busy_o[N];
  logic       fin_o[N];
  logic       te_o[N];
  logic [7:0] round_o[N];

  int sd_a[8];
  int vd_a[8];
  int prev_round[N];
  bit prev_te[N];
  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    select_validate_sequencer #(
      .NUM_ROUNDS     (P_NR[g]),
      .START_DELAY    (P_SD[g]),
      .GAP_CYCLES     (P_GAP[g]),
      .TIMEOUT_CYCLES (P_TO[g]),
      .CTR_W          (8)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start_i[g]),
      .select_test   (sel_o[g]),
      .select_done   (sel_done_i[g]),
      .validate      (val_o[g]),
      .validate_done (val_done_i[g]),
      .round         (round_o[g]),
      .busy          (busy_o[g]),
      .finish        (fin_o[g]),
      .timeout_err   (te_o[g])
    );
  end

  task automatic check(input string tag, input int idx, input int c,
                       input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s inst%0d cyc%0d: observed %0d expected %0d", tag, idx, c, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag, input int idx, input int c);
    check({tag, "_sel"}, idx, c, 32'(sel_o[idx]), 0);
    check({tag, "_val"}, idx, c, 32'(val_o[idx]), 0);
    check({tag, "_busy"}, idx, c, 32'(busy_o[idx]), 0);
    check({tag, "_fin"}, idx, c, 32'(fin_o[idx]), 0);
    check({tag, "_terr"}, idx, c, 32'(te_o[idx]), 0);
    check({tag, "_round"}, idx, c, 32'(round_o[idx]), 0);
  endtask

  task automatic fill(input int lo, input int hi);
    for (int i = 0; i < 8; i++) begin
      sd_a[i] = $urandom_range(hi, lo);
      vd_a[i] = $urandom_range(hi, lo);
    end
  endtask

  // Ack delays come from sd_a/vd_a (cycles after the strobe); a delay above the
  // timeout means the worker never answers. abort_c >= 0 applies rst at that cycle.
  task automatic run(input int idx, input bit early, input bit level, input bit spam,
                     input int abort_c);
    int nr, sd, gap, to, t, fin, last_r, last_c;
    int sel_t[8], val_t[8], sdn[8], vdn[8];
    bit to_hit;
    nr = P_NR[idx]; sd = P_SD[idx]; gap = P_GAP[idx]; to = P_TO[idx];
    for (int i = 0; i < 8; i++) begin
      sel_t[i] = -1; val_t[i] = -1; sdn[i] = -1; vdn[i] = -1;
    end
    t = 1 + sd; fin = 0; to_hit = 0; last_r = 0;
    for (int r = 0; r < nr; r++) begin
      sel_t[r] = t;
      last_r   = r;
      if (sd_a[r] > to) begin fin = t + to + 1; to_hit = 1; break; end
      sdn[r]   = t + sd_a[r];
      val_t[r] = sdn[r] + 1 + gap;
      if (vd_a[r] > to) begin fin = val_t[r] + to + 1; to_hit = 1; break; end
      vdn[r] = val_t[r] + vd_a[r];
      if (r == nr - 1) fin = vdn[r] + 1;
      else t = vdn[r] + 1;
    end
    last_c = (abort_c >= 0) ? abort_c : fin + 2;
    for (int c = 0; c <= last_c; c++) begin
      bit e_sel, e_val, sdrv, vdrv, e_te;
      int e_round;
      @(negedge clk);
      e_sel = 0; e_val = 0; sdrv = 0; vdrv = 0;
      e_round = (c == 0) ? prev_round[idx] : 0;
      for (int r = 0; r < nr; r++) begin
        if (sel_t[r] == c) e_sel = 1;
        if (val_t[r] == c) e_val = 1;
        if (c > 0 && r < nr - 1 && vdn[r] >= 0 && c > vdn[r]) e_round++;
        if (sdn[r] >= 0 && (c == sdn[r] || (level && c > sdn[r] && c < sdn[r] + 3))) sdrv = 1;
        if (vdn[r] >= 0 && (c == vdn[r] || (level && c > vdn[r] && c < vdn[r] + 3))) vdrv = 1;
        if (early && sel_t[r] == c) sdrv = 1;
        if (early && val_t[r] == c) vdrv = 1;
      end
      e_te = (c == 0) ? prev_te[idx] : ((c < fin) ? 1'b0 : to_hit);
      check("select_test", idx, c, 32'(sel_o[idx]), 32'(e_sel));
      check("validate", idx, c, 32'(val_o[idx]), 32'(e_val));
      check("finish", idx, c, 32'(fin_o[idx]), 32'(c == fin));
      check("busy", idx, c, 32'(busy_o[idx]), 32'(c >= 1 && c <= fin));
      check("round", idx, c, 32'(round_o[idx]), 32'(e_round));
      check("timeout_err", idx, c, 32'(te_o[idx]), 32'(e_te));
      if (c == abort_c) begin
        rst = 1'b1;
        #1;
        check_zero("rst_async", idx, c);
        repeat (2) begin
          @(negedge clk);
          check("rst_fin", idx, c, 32'(fin_o[idx]), 0);
          check("rst_busy", idx, c, 32'(busy_o[idx]), 0);
        end
        start_i[idx] = 1'b0; sel_done_i[idx] = 1'b0; val_done_i[idx] = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin prev_round[i] = 0; prev_te[i] = 0; end
        return;
      end
      start_i[idx]    = (c == 0) || (spam && c >= 2 && c <= fin && $urandom_range(2, 0) == 0);
      sel_done_i[idx] = sdrv;
      val_done_i[idx] = vdrv;
    end
    start_i[idx] = 1'b0; sel_done_i[idx] = 1'b0; val_done_i[idx] = 1'b0;
    prev_round[idx] = last_r;
    prev_te[idx]    = to_hit;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      start_i[i] = 1'b0; sel_done_i[i] = 1'b0; val_done_i[i] = 1'b0;
      prev_round[i] = 0; prev_te[i] = 0;
    end
    #1;
    for (int i = 0; i < N; i++) check_zero("reset", i, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // nominal run with defaults, workers ack 3 cycles after each strobe
    for (int i = 0; i < 8; i++) begin sd_a[i] = 3; vd_a[i] = 3; end
    run(0, 0, 0, 0, -1);
    // random ack delays with start hammered during the run
    fill(1, 8);
    run(0, 0, 0, 1, -1);
    // validate_done never comes in round 2
    fill(1, 5); vd_a[2] = 99;
    run(1, 0, 0, 0, -1);
    // next start clears the sticky timeout
    fill(1, 5);
    run(1, 0, 0, 1, -1);
    // ack on the exact expiry cycle wins over the timeout
    fill(1, 5); sd_a[1] = 16; vd_a[3] = 16;
    run(1, 0, 0, 0, -1);
    // one cycle later is a timeout in round 0
    fill(1, 5); sd_a[0] = 17;
    run(1, 0, 0, 0, -1);
    // zero gap: ack in the strobe cycle ignored, level ack afterwards
    fill(1, 4);
    run(2, 1, 1, 0, -1);
    for (int i = 0; i < 8; i++) begin sd_a[i] = 1; vd_a[i] = 1; end
    run(2, 1, 0, 1, -1);
    // reset mid-gap of round 1, then a fresh run from round 0
    fill(1, 1);
    run(1, 0, 0, 0, 24);
    run(1, 0, 0, 0, -1);
    // reset during a select_test strobe
    run(1, 0, 0, 0, 20);
    for (int k = 0; k < 6; k++) begin
      fill(1, (k % N == 0) ? 10 : 16);
      run(k % N, k[0], k[1], 1, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
